fifo_burst_writer: RTL

FIFO_BURST_WRITER -- requirements
Module: fifo_burst_writer

---
 rtl/fifo_burst_writer.sv | 121 ++++++++++++
 1 files changed

// File: rtl/fifo_burst_writer.sv
// fifo_burst_writer: emits a burst of BURST_LEN sequential data words into a
// FIFO, starting at a sampled seed, with IDLE_CYCLES forced gap cycles after
// every written word. Backpressure (fifo_full) holds the current word and is
// counted in a saturating stall counter.
//
// Optional feature: define FIFO_BURST_WRITER_THROTTLE_EN to also hold off
// writes while fifo_half_full is high (those cycles count as stalls too).
// Without the macro fifo_half_full is ignored but the port stays present.
module fifo_burst_writer #(
  parameter int DATA_WIDTH  = 32,
  parameter int BURST_LEN   = 1024,
  parameter int IDLE_CYCLES = 2
) (
  input  logic                               wr_clk,
  input  logic                               wr_rst_n,
  input  logic                               start,
  input  logic [DATA_WIDTH-1:0]              seed,
  input  logic                               abort,
  input  logic                               fifo_full,
  input  logic                               fifo_half_full,
  output logic                               fifo_wr_en,
  output logic [DATA_WIDTH-1:0]              fifo_wr_data,
  output logic                               busy,
  output logic                               done,
  output logic [$clog2(BURST_LEN+1)-1:0]     words_sent,
  output logic [15:0]                        stall_cycles
);

  localparam int WS_W  = $clog2(BURST_LEN+1);
  // Gap counter needs at least one bit even when gaps are disabled.
  localparam int GAP_W = (IDLE_CYCLES > 0) ? $clog2(IDLE_CYCLES+1) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]            state;
  logic [DATA_WIDTH-1:0] data;
  logic [WS_W-1:0]       ws_q;
  logic [15:0]           stall_q;
  logic [GAP_W-1:0]      gap_cnt;
  logic                  fifo_ok;
  logic                  in_write;
  logic                  last_word;

`ifdef FIFO_BURST_WRITER_THROTTLE_EN
  assign fifo_ok = !fifo_full && !fifo_half_full;
`else
  assign fifo_ok = !fifo_full;
  // Port kept for interface compatibility; intentionally has no effect.
  logic unused_half_full;
  assign unused_half_full = fifo_half_full;
`endif

  assign in_write   = (state == S_WRITE) && !abort;
  // Write strobe is combinational so a full flag blocks it in the same cycle.
  assign fifo_wr_en = in_write && fifo_ok;
  assign last_word  = (ws_q == WS_W'(BURST_LEN - 1));

  assign fifo_wr_data = data;
  assign busy         = (state != S_IDLE);
  assign done         = (state == S_DONE) && !abort;
  assign words_sent   = ws_q;
  assign stall_cycles = stall_q;

  // Burst sequencer: state, data word, word count, stall count and gap timer.
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      state   <= S_IDLE;
      data    <= '0;
      ws_q    <= '0;
      stall_q <= '0;
      gap_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            data    <= seed;
            ws_q    <= '0;
            stall_q <= '0;
            state   <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (abort) begin
            state <= S_IDLE;
          end else if (fifo_ok) begin
            data <= data + 1'b1;
            ws_q <= ws_q + 1'b1;
            if (last_word) begin
              state <= S_DONE;
            end else if (IDLE_CYCLES == 0) begin
              state <= S_WRITE;
            end else begin
              gap_cnt <= GAP_W'(IDLE_CYCLES);
              state   <= S_GAP;
            end
          end else if (stall_q != 16'hFFFF) begin
            // Blocked: word is held, only the stall counter moves.
            stall_q <= stall_q + 16'd1;
          end
        end
        S_GAP: begin
          if (abort) begin
            state <= S_IDLE;
          end else if (gap_cnt <= GAP_W'(1)) begin
            state <= S_WRITE;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: begin
          // S_DONE lasts one cycle; start here is deliberately ignored.
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
